ratio_avg: RTL and testbench
============================

RATIO_AVG -- requirements
Module: ratio_avg

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 3, meaning log2 of the averaging window length (legal 1..4; window N = 2^DEPTH_LOG2).
REQ-002 The block SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port areset, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port clear, input, 1, a synchronous window flush.
REQ-005 The block SHALL have port s_axis_ratio_tdata, input, 24, the 12.12 unsigned quotient from the upstream divider; 24'hffffff is the divide-by-zero code.
REQ-006 The block SHALL have port s_axis_ratio_tvalid, input, 1, which qualifies the sample; there is no input ready.
REQ-007 The block SHALL have port m_axis_avg_tdata, output, 24, the 12.12 windowed mean.
REQ-008 The block SHALL have port m_axis_avg_tvalid, output, 1, the output valid.
REQ-009 The block SHALL have port m_axis_avg_tready, input, 1, the downstream ready.
REQ-010 The block SHALL have port filled, output, 1, which is high once the window holds N valid samples.
REQ-011 The block SHALL have port err_cnt, output, 8, counting saturating divide-by-zero samples.
REQ-012 The block SHALL have port drop_cnt, output, 8, counting saturating samples lost to backpressure.

Function
REQ-013 The block SHALL implement states FILL and RUN; it SHALL enter FILL after reset or clear, and move FILL->RUN on the edge that accepts the Nth good sample.
REQ-014 Sample classification SHALL be applied in this priority order: clear > divide-by-zero > drop > accept.
REQ-015 A valid sample equal to 24'hffffff SHALL increment err_cnt and leave the window, sum and output untouched.
REQ-016 A valid good sample arriving while m_axis_avg_tvalid=1 and m_axis_avg_tready=0 SHALL be dropped and SHALL increment drop_cnt.
REQ-017 An accepted sample SHALL be written to a circular buffer at wr_ptr, and wr_ptr SHALL wrap modulo N.
REQ-018 On acceptance, sum (width 24+DEPTH_LOG2) SHALL update as sum + new - oldest, where oldest reads as 0 while in FILL.
REQ-019 Output SHALL be computed as (sum_next + 2^(DEPTH_LOG2-1)) >> DEPTH_LOG2, saturated to 24'hfffffe so that the divide-by-zero code is never emitted.
REQ-020 The 8th accepted sample in FILL SHALL itself produce an output; samples accepted earlier in FILL SHALL produce none.
REQ-021 Latency SHALL be one cycle: a sample accepted at edge k gives m_axis_avg_tvalid=1 after edge k.
REQ-022 m_axis_avg_tvalid and m_axis_avg_tdata SHALL hold stable until a cycle with m_axis_avg_tready=1, and valid SHALL drop after that cycle unless a new sample is accepted on the same edge.
REQ-023 A transfer (tvalid&tready) and an accept on the same edge SHALL load the new result with no bubble.
REQ-024 err_cnt and drop_cnt SHALL saturate at 255 and SHALL be cleared only by areset.
REQ-025 clear SHALL zero the sum and wr_ptr, deassert filled and m_axis_avg_tvalid, discard any same-cycle sample, and leave the counters unchanged.

Reset
REQ-026 On areset, the block SHALL set state=FILL, sum=0, wr_ptr=0, m_axis_avg_tdata=0, m_axis_avg_tvalid=0, filled=0, err_cnt=0 and drop_cnt=0; buffer contents need not be cleared.
REQ-027 An areset asserted mid-stream SHALL take effect on the next edge, and any pending output SHALL be lost.

Structure
REQ-028 A shared package ratio_pkg SHALL hold DATA_W=24, FRAC_W=12, DIV0_CODE=24'hffffff, SAT_MAX=24'hfffffe and CNT_W=8.
REQ-029 The circular buffer SHALL be a sub-module ratio_window_buf (N x 24, one write and one read port, combinational read of the oldest entry at wr_ptr).

Verification
REQ-030 Fill test: 8 samples of 0x001000 with tready=1 SHALL give exactly one output, 0x001000, on the cycle after the 8th sample, with filled=1.
REQ-031 Slide test: following the fill test, sample 0x009000 SHALL give output 0x002000.
REQ-032 Rounding test: after a fill of seven 0x000000 and one 0x000004, the output SHALL be 0x000001.
REQ-033 Divide-by-zero test: in RUN, injecting 0xffffff SHALL give no output and err_cnt=1, and the next good sample SHALL average the unchanged window.
REQ-034 Backpressure test: with tready=0, two good samples SHALL leave the first held on the output, and the second SHALL be dropped with drop_cnt=1; raising tready SHALL complete the transfer.
REQ-035 Reset and clear test: areset asserted mid-RUN, or clear coinciding with a valid sample, SHALL give tvalid=0 and filled=0, and re-entry to FILL SHALL require 8 new samples.

Source files
------------

// File: rtl/ratio_pkg.sv
// Shared constants and types for the ratio averaging datapath.
package ratio_pkg;
  localparam int DATA_W = 24;
  localparam int FRAC_W = 12;
  localparam int CNT_W  = 8;
  localparam logic [DATA_W-1:0] DIV0_CODE = 24'hffffff;
  localparam logic [DATA_W-1:0] SAT_MAX   = 24'hfffffe;

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic [DATA_W-FRAC_W-1:0] int_part;
    logic [FRAC_W-1:0]        frac_part;
  } q12_12_t;
endpackage

// File: rtl/ratio_avg_if.sv
// Sample-in / average-out stream bundle. The sample side has no ready;
// the average side is a valid/ready handshake.
interface ratio_avg_if;
  import ratio_pkg::*;

  logic [DATA_W-1:0] s_axis_ratio_tdata;
  logic              s_axis_ratio_tvalid;
  logic [DATA_W-1:0] m_axis_avg_tdata;
  logic              m_axis_avg_tvalid;
  logic              m_axis_avg_tready;

  modport slave (
    input  s_axis_ratio_tdata, s_axis_ratio_tvalid, m_axis_avg_tready,
    output m_axis_avg_tdata, m_axis_avg_tvalid
  );

  modport master (
    output s_axis_ratio_tdata, s_axis_ratio_tvalid, m_axis_avg_tready,
    input  m_axis_avg_tdata, m_axis_avg_tvalid
  );
endinterface

// File: rtl/ratio_window_buf.sv
// N-entry sample window: one synchronous write port, one combinational read port.
// Unreset storage; entries are only read once the window has been filled.
module ratio_window_buf
  import ratio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  aclk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_dat,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_dat
);
  logic [DATA_W-1:0] mem [1 << DEPTH_LOG2];

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/ratio_avg.sv
// Rounded moving mean over the last 2^DEPTH_LOG2 quotients, one cycle latency;
// no input ready, so good samples arriving while the output is stalled are dropped and counted.
module ratio_avg
  import ratio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             clear,
  ratio_avg_if.slave       axis,
  output logic             filled,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int SUM_W = DATA_W + DEPTH_LOG2;
  localparam logic [SUM_W-1:0] RND_HALF = SUM_W'(1) << (DEPTH_LOG2 - 1);

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [SUM_W-1:0]      sum_q, sum_d, sum_rnd, avg_wide;
  logic [DATA_W-1:0]     oldest, buf_rd, avg_sat, avg_dat_q;
  logic                  avg_vld_q, is_div0, is_drop, accept, emit;

  ratio_window_buf #(.DEPTH_LOG2(DEPTH_LOG2)) u_buf (
    .aclk    (aclk),
    .wr_en   (accept),
    .wr_addr (wr_ptr_q),
    .wr_dat  (axis.s_axis_ratio_tdata),
    .rd_addr (wr_ptr_q),
    .rd_dat  (buf_rd)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div0  = 1'b0;
    is_drop  = 1'b0;
    accept   = 1'b0;
    emit     = 1'b0;
    oldest   = '0;
    // clear outranks every sample class, so a flushed sample is neither counted nor stored
    if (!clear && axis.s_axis_ratio_tvalid) begin
      if (axis.s_axis_ratio_tdata == DIV0_CODE) begin
        is_div0 = 1'b1;
      end else if (avg_vld_q && !axis.m_axis_avg_tready) begin
        is_drop = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end
    if (state_q == ST_RUN) begin
      oldest = buf_rd;
    end
    sum_d    = sum_q + SUM_W'(axis.s_axis_ratio_tdata) - SUM_W'(oldest);
    sum_rnd  = sum_d + RND_HALF;
    avg_wide = sum_rnd >> DEPTH_LOG2;
    avg_sat  = (avg_wide > SUM_W'(SAT_MAX)) ? SAT_MAX : avg_wide[DATA_W-1:0];
    case (state_q)
      ST_FILL: begin
        if (accept && (&wr_ptr_q)) begin
          state_d = ST_RUN;
          emit    = 1'b1;
        end
      end
      ST_RUN:  emit = accept;
      default: state_d = ST_FILL;
    endcase
    if (clear) begin
      state_d = ST_FILL;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      sum_q     <= '0;
      wr_ptr_q  <= '0;
      avg_dat_q <= '0;
      avg_vld_q <= 1'b0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (is_div0 && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (is_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (clear) begin
        sum_q     <= '0;
        wr_ptr_q  <= '0;
        avg_vld_q <= 1'b0;
      end else begin
        if (accept) begin
          sum_q    <= sum_d;
          wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
        end
        // a new result overrides the pending drop of valid after a transfer
        if (emit) begin
          avg_vld_q <= 1'b1;
          avg_dat_q <= avg_sat;
        end else if (axis.m_axis_avg_tready) begin
          avg_vld_q <= 1'b0;
        end
      end
    end
  end

  assign axis.m_axis_avg_tdata  = avg_dat_q;
  assign axis.m_axis_avg_tvalid = avg_vld_q;
  assign filled                 = (state_q == ST_RUN);
endmodule

// File: tb/tb_ratio_avg.sv
// Directed bench for ratio_avg: stimulus pushes hand-computed averages into a
// scoreboard queue, a negedge monitor pops and compares each output transfer.
module tb_ratio_avg;
  logic       aclk = 1'b0;
  logic       areset;
  logic       clear;
  logic       filled;
  logic [7:0] err_cnt;
  logic [7:0] drop_cnt;

  int checks   = 0;
  int failures = 0;
  logic [23:0] sb[$];
  logic [23:0] exp_v;

  ratio_avg_if axis ();

  ratio_avg #(.DEPTH_LOG2(3)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .clear    (clear),
    .axis     (axis),
    .filled   (filled),
    .err_cnt  (err_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [23:0] d);
    axis.s_axis_ratio_tdata  = d;
    axis.s_axis_ratio_tvalid = 1'b1;
    tick();
    axis.s_axis_ratio_tvalid = 1'b0;
  endtask

  task automatic send_exp(input logic [23:0] d, input logic [23:0] e);
    sb.push_back(e);
    send(d);
  endtask

  // Output monitor: a transfer happens at the next rising edge when valid&ready.
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset && axis.m_axis_avg_tvalid && axis.m_axis_avg_tready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", axis.m_axis_avg_tdata);
        end else begin
          exp_v = sb.pop_front();
          chk("out_data", {8'h0, axis.m_axis_avg_tdata}, {8'h0, exp_v});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset = 1'b1;
    clear  = 1'b0;
    axis.s_axis_ratio_tdata  = '0;
    axis.s_axis_ratio_tvalid = 1'b0;
    axis.m_axis_avg_tready   = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    chk("rst_tvalid", {31'h0, axis.m_axis_avg_tvalid}, 32'h0);
    chk("rst_tdata", {8'h0, axis.m_axis_avg_tdata}, 32'h0);
    chk("rst_filled", {31'h0, filled}, 32'h0);
    chk("rst_err", {24'h0, err_cnt}, 32'h0);
    chk("rst_drop", {24'h0, drop_cnt}, 32'h0);

    // Fill: only the eighth sample produces a result
    for (int i = 0; i < 7; i++) send(24'h001000);
    chk("fill_filled_early", {31'h0, filled}, 32'h0);
    chk("fill_tvalid_early", {31'h0, axis.m_axis_avg_tvalid}, 32'h0);
    send_exp(24'h001000, 24'h001000);
    chk("fill_filled", {31'h0, filled}, 32'h1);
    chk("fill_tvalid", {31'h0, axis.m_axis_avg_tvalid}, 32'h1);
    tick();

    // Slide: (7*0x1000 + 0x9000) / 8 = 0x2000
    send_exp(24'h009000, 24'h002000);
    tick();

    // Divide-by-zero leaves the window alone
    send(24'hffffff);
    chk("div0_err", {24'h0, err_cnt}, 32'h1);
    chk("div0_tvalid", {31'h0, axis.m_axis_avg_tvalid}, 32'h0);
    send_exp(24'h001000, 24'h002000);

    // Back-to-back: transfer and accept on the same edge
    send_exp(24'h001000, 24'h002000);
    send_exp(24'h001000, 24'h002000);
    tick();

    // Backpressure: first result held, second sample dropped
    axis.m_axis_avg_tready = 1'b0;
    send_exp(24'h001000, 24'h002000);
    send(24'h005000);
    chk("bp_drop", {24'h0, drop_cnt}, 32'h1);
    chk("bp_tvalid_hold", {31'h0, axis.m_axis_avg_tvalid}, 32'h1);
    chk("bp_tdata_hold", {8'h0, axis.m_axis_avg_tdata}, 32'h002000);
    axis.m_axis_avg_tready = 1'b1;
    tick();
    chk("bp_tvalid_done", {31'h0, axis.m_axis_avg_tvalid}, 32'h0);

    // Clear with a pending output and a coincident sample
    axis.m_axis_avg_tready = 1'b0;
    send_exp(24'h001000, 24'h002000);
    clear = 1'b1;
    axis.s_axis_ratio_tdata  = 24'h007000;
    axis.s_axis_ratio_tvalid = 1'b1;
    tick();
    clear = 1'b0;
    axis.s_axis_ratio_tvalid = 1'b0;
    sb.delete();
    chk("clr_tvalid", {31'h0, axis.m_axis_avg_tvalid}, 32'h0);
    chk("clr_filled", {31'h0, filled}, 32'h0);
    chk("clr_err_kept", {24'h0, err_cnt}, 32'h1);
    chk("clr_drop_kept", {24'h0, drop_cnt}, 32'h1);
    axis.m_axis_avg_tready = 1'b1;

    // Rounding: (4 + 4) >> 3 = 1
    for (int i = 0; i < 7; i++) send(24'h000000);
    chk("rnd_filled_early", {31'h0, filled}, 32'h0);
    send_exp(24'h000004, 24'h000001);
    tick();

    // Top of range: mean of 0xfffffe stays 0xfffffe
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) send(24'hfffffe);
    send_exp(24'hfffffe, 24'hfffffe);
    tick();

    // Reset mid-RUN with a stalled result: (7*0xfffffe + 2 + 4) >> 3 = 0xdfffff
    axis.m_axis_avg_tready = 1'b0;
    send_exp(24'h000002, 24'hdfffff);
    chk("pre_rst_tdata", {8'h0, axis.m_axis_avg_tdata}, 32'hdfffff);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    sb.delete();
    axis.m_axis_avg_tready = 1'b1;
    chk("mrst_tvalid", {31'h0, axis.m_axis_avg_tvalid}, 32'h0);
    chk("mrst_filled", {31'h0, filled}, 32'h0);
    chk("mrst_err", {24'h0, err_cnt}, 32'h0);
    chk("mrst_drop", {24'h0, drop_cnt}, 32'h0);
    for (int i = 0; i < 7; i++) send(24'h000010);
    chk("refill_filled_early", {31'h0, filled}, 32'h0);
    send_exp(24'h000010, 24'h000010);
    chk("refill_filled", {31'h0, filled}, 32'h1);
    tick();
    tick();

    chk("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
